vga_timing_gen_param: RTL and testbench

- Parametrised successor to the fixed 640x480 screen generator.
- Generates VGA h_sync/v_sync timing from one system clock, using a pixel clock-enable divider.
- Timing, sync polarity, colour depth and pixel divide ratio are all parameters.
- Adds a data-enable output, pixel coordinates, frame/line strobes, and a runtime-selectable test-pattern source.
- The pattern mode is changed only on a frame boundary, so it never tears mid-frame.
- Sits between the top-level clock and the VGA connector pins.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_axis_counter.sv | 39 +++
 rtl/vga_timing_gen_param.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen_param.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the parametrised VGA timing generator: pattern
// modes, default 640x480@60 timing and a width helper.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus its visible and sync
// windows. Used once per line (horizontal) and once per frame (vertical).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = 1'b0,
  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int unsigned W     = clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int unsigned SYNC_FIRST = ACTIVE + FP;
  localparam int unsigned SYNC_LAST  = ACTIVE + FP + SYNC - 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

  // Inclusive upper bounds keep every constant inside W bits.
  assign wrap   = (count == W'(TOTAL - 1));
  assign active = (count <= W'(ACTIVE - 1));
  assign sync   = (count >= W'(SYNC_FIRST) && count <= W'(SYNC_LAST)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator with pixel clock-enable divider,
// registered sync/data-enable/coordinates and a frame-latched test pattern.
module vga_timing_gen_param
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned CHECK_LOG2 = 3,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW        = clog2(H_TOTAL),
  localparam int unsigned YW        = clog2(V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] fg_color,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic [COLOR_W-1:0]   r_out,
  output logic [COLOR_W-1:0]   g_out,
  output logic [COLOR_W-1:0]   b_out,
  output logic                 de,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic                 frame_start,
  output logic                 line_start
);

  localparam int unsigned DW    = clog2(CLK_DIV);
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned RGB_W = 3 * COLOR_W;

  logic [DW-1:0]    div;
  logic             tick;
  logic [XW-1:0]    h_cnt;
  logic [YW-1:0]    v_cnt;
  logic             h_wrap, v_wrap, h_act, v_act, h_sync_c, v_sync_c;
  mode_e            active_mode;
  logic [RGB_W-1:0] active_fg;
  logic [RGB_W-1:0] pix;
  logic [2:0]       bar;
  logic             check_on;

  // Pixel clock enable: one tick every CLK_DIV clocks, always high when CLK_DIV is 1.
  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_axis (
    .clk(clk), .rst(rst), .tick(tick),
    .count(h_cnt), .wrap(h_wrap), .active(h_act), .sync(h_sync_c)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_axis (
    .clk(clk), .rst(rst), .tick(tick && h_wrap),
    .count(v_cnt), .wrap(v_wrap), .active(v_act), .sync(v_sync_c)
  );

  // Pattern source for the current pixel, blanked outside the visible area.
  always_comb begin
    pix      = '0;
    bar      = 3'(32'(h_cnt) / BAR_W);
    check_on = 1'((32'(h_cnt) ^ 32'(v_cnt)) >> CHECK_LOG2);
    if (h_act && v_act) begin
      case (active_mode)
        MODE_BARS:  pix = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
        MODE_CHECK: pix = check_on ? active_fg : '0;
        MODE_SOLID: pix = active_fg;
        default:    pix = '0;
      endcase
    end
  end

  // Output register, one pixel behind the counters; strobes last one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync      <= ~HS_POL;
      v_sync      <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      active_mode <= mode_e'(mode);
      active_fg   <= fg_color;
    end else begin
      // Pattern selection only changes on the last pixel of a frame.
      if (tick && h_wrap && v_wrap) begin
        active_mode <= mode_e'(mode);
        active_fg   <= fg_color;
      end
      if (tick) begin
        h_sync                 <= h_sync_c;
        v_sync                 <= v_sync_c;
        de                     <= h_act && v_act;
        x                      <= h_cnt;
        y                      <= v_cnt;
        {r_out, g_out, b_out}  <= pix;
        frame_start            <= (h_cnt == '0) && (v_cnt == '0);
        line_start             <= (h_cnt == '0);
      end else begin
        frame_start <= 1'b0;
        line_start  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Bench for vga_timing_gen_param in a 16x8 pixel-total configuration:
// table vectors, timing/mode/reset sequences and a random model-checked run.
`timescale 1ns/1ps
module tb_vga_timing_gen_param;

  localparam int unsigned HA = 8, HF = 2, HSW = 3, HB = 3;
  localparam int unsigned VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int unsigned CD = 2, CW = 4, CL = 1;
  localparam int unsigned HT = HA + HF + HSW + HB;
  localparam int unsigned VT = VA + VF + VSW + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned FRAME_CLK = FRAME * CD;
  localparam int unsigned LINE_CLK = HT * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [11:0] fg_color = 12'h000;
  logic        h_sync, v_sync, de, frame_start, line_start;
  logic [3:0]  r_out, g_out, b_out;
  logic [3:0]  x;
  logic [2:0]  y;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic       hs, vs, de;
    logic [3:0] r, g, b;
    logic [3:0] x;
    logic [2:0] y;
    logic       fs, ls;
  } obs_t;

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] fg;
    int unsigned px, py;
    logic [11:0] rgb;
  } vec_t;

  vga_timing_gen_param #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(CD), .COLOR_W(CW), .CHECK_LOG2(CL)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .fg_color(fg_color),
    .h_sync(h_sync), .v_sync(v_sync), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .de(de), .x(x), .y(y), .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  function automatic obs_t observe();
    obs_t o;
    o = '{hs: h_sync, vs: v_sync, de: de, r: r_out, g: g_out, b: b_out,
          x: x, y: y, fs: frame_start, ls: line_start};
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Expected registered outputs for pixel number p counted from frame origin.
  function automatic obs_t ref_pixel(input int unsigned p, input logic [1:0] m,
                                     input logic [11:0] fg, input bit strobe);
    obs_t o;
    int unsigned hp, vp, bar;
    hp = p % HT;
    vp = (p / HT) % VT;
    o = '0;
    o.hs = !(hp >= HA + HF && hp < HA + HF + HSW);
    o.vs = !(vp >= VA + VF && vp < VA + VF + VSW);
    o.de = (hp < HA) && (vp < VA);
    o.x  = 4'(hp);
    o.y  = 3'(vp);
    o.fs = strobe && hp == 0 && vp == 0;
    o.ls = strobe && hp == 0;
    if (o.de) begin
      case (m)
        2'd1: begin
          bar = hp / (HA / 8);
          o.r = ((bar & 4) != 0) ? 4'hF : 4'h0;
          o.g = ((bar & 2) != 0) ? 4'hF : 4'h0;
          o.b = ((bar & 1) != 0) ? 4'hF : 4'h0;
        end
        2'd2: if ((((hp >> CL) ^ (vp >> CL)) & 1) == 1) {o.r, o.g, o.b} = fg;
        2'd3: {o.r, o.g, o.b} = fg;
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [11:0] fg);
    @(negedge clk);
    mode = m;
    fg_color = fg;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pixel(input int unsigned px, input int unsigned py, output bit ok);
    bit seen;
    seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (frame_start) seen = 1'b1;
      if (seen && x == 4'(px) && y == 3'(py)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Frame/line periods and sync/de windows measured over one whole frame.
  task automatic seq_timing();
    int unsigned rel, c, fs0, fs1, ls_prev, ls_cnt, hs_first, hs_low;
    int unsigned vs_first, vs_low, de_cnt, de_last;
    bit got0, got1, ls_bad;
    {fs0, fs1, ls_prev, ls_cnt, hs_first, hs_low, vs_first, vs_low, de_cnt, de_last} = '0;
    {got0, got1, ls_bad} = '0;
    do_reset(2'd1, 12'h000);
    rel = cyc;
    for (int i = 0; i < 2 * FRAME_CLK + 8; i++) begin
      @(negedge clk);
      c = cyc;
      if (frame_start) begin
        if (!got0) begin fs0 = c; got0 = 1'b1; end
        else begin fs1 = c; got1 = 1'b1; break; end
      end
      if (got0) begin
        if (line_start) begin
          if (ls_cnt > 0 && c - ls_prev != LINE_CLK) ls_bad = 1'b1;
          ls_prev = c;
          ls_cnt++;
        end
        if (!h_sync) begin if (hs_low == 0) hs_first = c; hs_low++; end
        if (!v_sync) begin if (vs_low == 0) vs_first = c; vs_low++; end
        if (de) begin de_cnt++; de_last = c; end
      end
    end
    check("first_frame_start", 32'(fs0 - rel), 32'd2);
    check("frame_period", got1 ? 32'(fs1 - fs0) : 32'd0, 32'(FRAME_CLK));
    check("line_count", 32'(ls_cnt), 32'd8);
    check("line_period", 32'(ls_bad), 32'd0);
    check("hsync_start", 32'(hs_first - fs0), 32'd20);
    check("hsync_low_clks", 32'(hs_low), 32'd48);
    check("vsync_start", 32'(vs_first - fs0), 32'd160);
    check("vsync_low_clks", 32'(vs_low), 32'd64);
    check("de_clks", 32'(de_cnt), 32'd64);
    check("de_last", 32'(de_last - fs0), 32'd111);
  endtask

  // Mode 0 -> 3 mid-frame: rest of frame stays black, next frame is solid fg.
  task automatic seq_mode_switch();
    int unsigned phase, k, black_bad, vis, mism;
    {phase, k, black_bad, vis, mism} = '0;
    do_reset(2'd0, 12'h000);
    for (int i = 0; i < 3 * FRAME_CLK && phase < 3; i++) begin
      @(negedge clk);
      if (frame_start) phase++;
      if (phase == 1) begin
        if ({r_out, g_out, b_out} != 12'h000) black_bad++;
        k++;
        if (k == 100) begin mode = 2'd3; fg_color = 12'hA5C; end
      end else if (phase == 2) begin
        if (de) begin
          vis++;
          if ({r_out, g_out, b_out} != 12'hA5C) mism++;
        end else if ({r_out, g_out, b_out} != 12'h000) begin
          mism++;
        end
      end
    end
    check("switch_reached", 32'(phase), 32'd3);
    check("switch_old_frame_black", 32'(black_bad), 32'd0);
    check("switch_visible_clks", 32'(vis), 32'd64);
    check("switch_new_frame_fg", 32'(mism), 32'd0);
  endtask

  // One-clock reset in the middle of a line.
  task automatic seq_reset_mid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * LINE_CLK; i++) begin
      @(negedge clk);
      if (line_start && y == 3'd1) begin ok = 1'b1; break; end
    end
    check("midline_found", 32'(ok), 32'd1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midline_reset_state", 32'(observe()), 32'(reset_obs()));
    rst = 1'b0;
    @(negedge clk);
    check("midline_hold", 32'(observe()), 32'(reset_obs()));
    @(negedge clk);
    check("midline_restart", 32'(observe()), 32'(ref_pixel(0, 2'd3, 12'hA5C, 1'b1)));
  endtask

  // Random inputs against a pixel-index model counted from reset release.
  task automatic rand_run(input int unsigned ncyc);
    int unsigned n, p;
    logic        r_i;
    logic [1:0]  m_i, am;
    logic [11:0] f_i, afg;
    obs_t        e;
    n = 0;
    am = 2'd0;
    afg = 12'h000;
    e = reset_obs();
    for (int unsigned i = 0; i < ncyc; i++) begin
      @(negedge clk);
      r_i = (i < 2) || ($urandom_range(0, 699) == 0);
      m_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : mode;
      f_i = ($urandom_range(0, 3) == 0) ? 12'($urandom) : fg_color;
      rst = r_i;
      mode = m_i;
      fg_color = f_i;
      @(posedge clk);
      if (r_i) begin
        n = 0;
        am = m_i;
        afg = f_i;
        e = reset_obs();
      end else begin
        n++;
        if (n % CD == 0) begin
          p = n / CD - 1;
          e = ref_pixel(p, am, afg, 1'b1);
          if (p % FRAME == FRAME - 1) begin am = m_i; afg = f_i; end
        end else begin
          e.fs = 1'b0;
          e.ls = 1'b0;
        end
      end
      #1;
      check("model", 32'(observe()), 32'(e));
    end
  endtask

  initial begin
    vec_t tbl[11];
    bit ok;
    tbl[0]  = '{mode: 2'd1, fg: 12'h000, px: 5, py: 0, rgb: 12'hF0F};
    tbl[1]  = '{mode: 2'd1, fg: 12'h000, px: 0, py: 0, rgb: 12'h000};
    tbl[2]  = '{mode: 2'd1, fg: 12'h000, px: 7, py: 2, rgb: 12'hFFF};
    tbl[3]  = '{mode: 2'd1, fg: 12'h000, px: 3, py: 1, rgb: 12'h0FF};
    tbl[4]  = '{mode: 2'd1, fg: 12'h000, px: 6, py: 3, rgb: 12'hFF0};
    tbl[5]  = '{mode: 2'd1, fg: 12'h000, px: 9, py: 0, rgb: 12'h000};
    tbl[6]  = '{mode: 2'd2, fg: 12'hABC, px: 2, py: 0, rgb: 12'hABC};
    tbl[7]  = '{mode: 2'd2, fg: 12'hABC, px: 2, py: 2, rgb: 12'h000};
    tbl[8]  = '{mode: 2'd3, fg: 12'hA5C, px: 4, py: 3, rgb: 12'hA5C};
    tbl[9]  = '{mode: 2'd3, fg: 12'hA5C, px: 4, py: 5, rgb: 12'h000};
    tbl[10] = '{mode: 2'd0, fg: 12'hFFF, px: 3, py: 1, rgb: 12'h000};

    repeat (3) @(negedge clk);
    check("reset_state", 32'(observe()), 32'(reset_obs()));

    foreach (tbl[i]) begin
      do_reset(tbl[i].mode, tbl[i].fg);
      wait_pixel(tbl[i].px, tbl[i].py, ok);
      if (!ok) check($sformatf("tbl%0d_timeout", i), 32'd0, 32'd1);
      else check($sformatf("tbl%0d_rgb", i), 32'({r_out, g_out, b_out}), 32'(tbl[i].rgb));
    end

    seq_timing();
    seq_mode_switch();
    seq_reset_mid();
    rand_run(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
